// File: rtl/img_acc_pkg.sv
// Shared definitions for the input-memory image path.
// Holds the default geometry of the packed memory word and the state
// encoding of the pixel packer FSM.
package img_acc_pkg;

    localparam int DEF_ADD_SIZE     = 12;   // memory word address width
    localparam int DEF_DATA_SIZE    = 108;  // packed memory word width
    localparam int DEF_PIX_W        = 12;   // pixel width
    localparam int DEF_PIX_PER_WORD = DEF_DATA_SIZE / DEF_PIX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        DRAIN = 2'd2
    } packer_state_t;

endpackage

// File: rtl/input_pixel_packer.sv
// input_pixel_packer
//   Packs a frame of PIX_W-bit pixels into DATA_SIZE-bit memory words and
//   issues them, with an auto-incrementing word address, on the write
//   request interface of write_mem_controller. A partial word at frame end
//   is flushed zero-padded; frame_done pulses once the last word is taken.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset (0 = reset)
//   start      : 1-cycle pulse, begins a frame at base_addr (ignored if busy)
//   base_addr  : first word address of the frame, sampled on start
//   pix_valid  : pixel stream valid
//   pix_data   : pixel value
//   pix_last   : marks the final pixel of the frame
//   pix_ready  : pixel accepted this cycle when high with pix_valid
//   write_en   : write request, identical to in_valid
//   in_valid   : address_in/dataIn valid
//   address_in : word address of the presented word
//   dataIn     : packed word, pixel 0 in bits [PIX_W-1:0]
//   out_ready  : downstream accepts the word when high with in_valid
//   busy       : high in PACK and DRAIN
//   frame_done : 1-cycle pulse after the last word of a frame is accepted
//   word_count : words accepted downstream this frame (wraps)
//
// Handshakes: both interfaces use strict valid/ready. A beat transfers on a
// rising edge where valid and ready are both high; the producer holds its
// payload stable while valid is high and ready is low, and valid never
// depends combinationally on ready. pix_ready does depend on out_ready so a
// completing pixel can be taken in the same cycle the pending word leaves.
module input_pixel_packer #(
    parameter int ADD_SIZE  = img_acc_pkg::DEF_ADD_SIZE,
    parameter int DATA_SIZE = img_acc_pkg::DEF_DATA_SIZE,
    parameter int PIX_W     = img_acc_pkg::DEF_PIX_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADD_SIZE-1:0]  base_addr,
    input  logic                 pix_valid,
    input  logic [PIX_W-1:0]     pix_data,
    input  logic                 pix_last,
    output logic                 pix_ready,
    output logic                 write_en,
    output logic                 in_valid,
    output logic [ADD_SIZE-1:0]  address_in,
    output logic [DATA_SIZE-1:0] dataIn,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 frame_done,
    output logic [ADD_SIZE-1:0]  word_count
);
    import img_acc_pkg::*;

    localparam int PIX_PER_WORD = DATA_SIZE / PIX_W;
    localparam int CNT_W        = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

    generate
        if (DATA_SIZE % PIX_W != 0) begin : g_bad_geometry
            $error("input_pixel_packer: DATA_SIZE must be a multiple of PIX_W");
        end
    endgenerate

    packer_state_t        state_q,      state_d;
    logic [CNT_W-1:0]     cnt_q,        cnt_d;
    logic [DATA_SIZE-1:0] acc_q,        acc_d;
    logic [ADD_SIZE-1:0]  addr_ptr_q,   addr_ptr_d;
    logic                 in_valid_q,   in_valid_d;
    logic [ADD_SIZE-1:0]  address_q,    address_d;
    logic [DATA_SIZE-1:0] data_q,       data_d;
    logic [ADD_SIZE-1:0]  word_count_q, word_count_d;
    logic                 frame_done_q, frame_done_d;

    logic                 xfer;
    logic                 pix_accept;
    logic                 word_done;
    logic [DATA_SIZE-1:0] merged_word;

    // A new pixel may enter only when the output register is free or is
    // being emptied on this very edge, so a pending word is never overwritten.
    assign pix_ready  = (state_q == PACK) && (!in_valid_q || out_ready);
    assign xfer       = in_valid_q && out_ready;
    assign pix_accept = pix_valid && pix_ready;
    assign word_done  = pix_accept &&
                        (pix_last || (cnt_q == CNT_W'(PIX_PER_WORD - 1)));

    always_comb begin
        // Accumulator with the incoming pixel dropped into its slot; slots
        // above cnt are still zero, which provides the padding on a flush.
        merged_word = acc_q;
        for (int i = 0; i < PIX_PER_WORD; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                merged_word[i*PIX_W +: PIX_W] = pix_data;
            end
        end

        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        addr_ptr_d   = addr_ptr_q;
        in_valid_d   = in_valid_q;
        address_d    = address_q;
        data_d       = data_q;
        word_count_d = word_count_q;
        frame_done_d = 1'b0;

        if (xfer) begin
            in_valid_d   = 1'b0;
            word_count_d = word_count_q + ADD_SIZE'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = PACK;
                    addr_ptr_d   = base_addr;
                    word_count_d = '0;
                    cnt_d        = '0;
                    acc_d        = '0;
                end
            end
            PACK: begin
                if (pix_accept) begin
                    if (word_done) begin
                        // Overrides the drop of in_valid from a same-cycle
                        // transfer: the register reloads back-to-back.
                        in_valid_d = 1'b1;
                        data_d     = merged_word;
                        address_d  = addr_ptr_q;
                        addr_ptr_d = addr_ptr_q + ADD_SIZE'(1);
                        cnt_d      = '0;
                        acc_d      = '0;
                    end else begin
                        acc_d = merged_word;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (pix_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Only the final word can be pending here; its transfer ends the frame.
                if (xfer) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            addr_ptr_q   <= '0;
            in_valid_q   <= 1'b0;
            address_q    <= '0;
            data_q       <= '0;
            word_count_q <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            addr_ptr_q   <= addr_ptr_d;
            in_valid_q   <= in_valid_d;
            address_q    <= address_d;
            data_q       <= data_d;
            word_count_q <= word_count_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign in_valid   = in_valid_q;
    assign write_en   = in_valid_q;
    assign address_in = address_q;
    assign dataIn     = data_q;
    assign busy       = (state_q == PACK) || (state_q == DRAIN);
    assign frame_done = frame_done_q;
    assign word_count = word_count_q;

endmodule
